// File: rtl/priority_encoder_pkg.sv
// +----------------------------------------------------------------------+
// | priority_encoder_pkg : shared widths, width helper and index type      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package priority_encoder_pkg;

   localparam int unsigned PE_OUT_WIDTH = 4;

   function automatic int unsigned pe_in_width(input int unsigned out_width);
      return 32'd1 << out_width;
   endfunction

   typedef logic [PE_OUT_WIDTH-1:0] pe_idx_t;

endpackage

`default_nettype wire

// File: rtl/priority_encoder_if.sv
// +----------------------------------------------------------------------+
// | priority_encoder_if : grant vector in, encoded index and flags out    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface priority_encoder_if
   import priority_encoder_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = PE_OUT_WIDTH,
   parameter int unsigned IN_WIDTH  = pe_in_width(OUT_WIDTH)
);

   logic [IN_WIDTH-1:0]  gnt;
   logic [OUT_WIDTH-1:0] enc;
   logic                 valid;
   logic                 multi;
   logic [OUT_WIDTH-1:0] enc_comb;

   modport master (
      output gnt,
      input  enc,
      input  valid,
      input  multi,
      input  enc_comb
   );

   modport slave (
      input  gnt,
      output enc,
      output valid,
      output multi,
      output enc_comb
   );

endinterface

`default_nettype wire

// File: rtl/priority_encoder_pe_or_encode.sv
// +----------------------------------------------------------------------+
// | pe_or_encode : combinational OR-based one-hot to binary encoder        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pe_or_encode
   import priority_encoder_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = PE_OUT_WIDTH,
   parameter int unsigned IN_WIDTH  = pe_in_width(OUT_WIDTH)
) (
   input  wire logic [IN_WIDTH-1:0]  gnt,
   output      logic [OUT_WIDTH-1:0] enc
);

   // Index 0 has no bits set, so gnt[0] never reaches any output bit.
   logic w_unused_bit0;
   assign w_unused_bit0 = gnt[0];

   for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_bit
      logic [IN_WIDTH-2:0] w_mask;
      for (genvar j = 1; j < IN_WIDTH; j++) begin : g_sel
         if (((j >> i) & 1) == 1) begin : g_take
            assign w_mask[j-1] = gnt[j];
         end else begin : g_skip
            assign w_mask[j-1] = 1'b0;
         end
      end
      assign enc[i] = |w_mask;
   end

endmodule

`default_nettype wire

// File: rtl/priority_encoder.sv
// +----------------------------------------------------------------------+
// | priority_encoder : registered grant encoder with any/multi-hot flags  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_encoder
   import priority_encoder_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = PE_OUT_WIDTH,
   parameter int unsigned IN_WIDTH  = pe_in_width(OUT_WIDTH)
) (
   input  wire logic            clock,
   input  wire logic            reset_n,
   priority_encoder_if.slave    bus
);

   if ((OUT_WIDTH < 1) || (IN_WIDTH != (32'd1 << OUT_WIDTH))) begin : g_param_err
      $error("priority_encoder: IN_WIDTH must equal 1<<OUT_WIDTH with OUT_WIDTH >= 1");
   end

   logic [OUT_WIDTH-1:0] enc_d;
   logic                 valid_d;
   logic                 multi_d;
   logic [OUT_WIDTH-1:0] enc_q;
   logic                 valid_q;
   logic                 multi_q;

   pe_or_encode #(
      .OUT_WIDTH (OUT_WIDTH),
      .IN_WIDTH  (IN_WIDTH)
   ) u_or_encode (
      .gnt (bus.gnt),
      .enc (enc_d)
   );

   // Pairwise tree: a node is multi-hot if either child is, or both children are non-zero.
   for (genvar l = 0; l <= OUT_WIDTH; l++) begin : g_lvl
      localparam int unsigned N = IN_WIDTH >> l;
      logic [N-1:0] w_any;
      logic [N-1:0] w_multi;
      if (l == 0) begin : g_leaf
         assign w_any   = bus.gnt;
         assign w_multi = '0;
      end else begin : g_node
         for (genvar n = 0; n < N; n++) begin : g_pair
            assign w_any[n]   = g_lvl[l-1].w_any[2*n] | g_lvl[l-1].w_any[2*n+1];
            assign w_multi[n] = g_lvl[l-1].w_multi[2*n] | g_lvl[l-1].w_multi[2*n+1]
                              | (g_lvl[l-1].w_any[2*n] & g_lvl[l-1].w_any[2*n+1]);
         end
      end
   end

   assign valid_d = |bus.gnt;
   assign multi_d = g_lvl[OUT_WIDTH].w_multi[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enc_q   <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         enc_q   <= enc_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign bus.enc      = enc_q;
   assign bus.valid    = valid_q;
   assign bus.multi    = multi_q;
   assign bus.enc_comb = enc_d;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder.sv
// +----------------------------------------------------------------------+
// | tb_priority_encoder : directed self-checking bench for priority_encoder|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_priority_encoder;
   import priority_encoder_pkg::*;

   logic clock;
   logic reset_n;
   int   tests;
   int   failed;

   priority_encoder_if #(.OUT_WIDTH(4)) bus ();

   priority_encoder #(.OUT_WIDTH(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input pe_idx_t e, input logic v, input logic m);
      chk({tag, ".enc"},   32'(bus.enc),   32'(e));
      chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
      chk({tag, ".multi"}, 32'(bus.multi), 32'(m));
   endtask

   // Drive on the falling edge, check the combinational encode, then the registers after the rise.
   task automatic step(input string tag, input logic [15:0] g, input pe_idx_t e,
                       input logic v, input logic m);
      @(negedge clock);
      bus.gnt = g;
      #1;
      chk({tag, ".enc_comb"}, 32'(bus.enc_comb), 32'(e));
      @(posedge clock);
      #1;
      chk_regs(tag, e, v, m);
   endtask

   initial begin
      tests   = 0;
      failed  = 0;
      reset_n = 1'b0;
      bus.gnt = 16'h1000;

      #2;
      chk_regs("reset", 4'd0, 1'b0, 1'b0);
      chk("reset.enc_comb", 32'(bus.enc_comb), 32'd12);
      @(posedge clock);
      #1;
      chk_regs("reset_hold", 4'd0, 1'b0, 1'b0);

      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk_regs("post_release", 4'd0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      chk_regs("first_capture", 4'd12, 1'b1, 1'b0);

      step("oh_3",  16'h0008, 4'd3,  1'b1, 1'b0);
      step("oh_7",  16'h0080, 4'd7,  1'b1, 1'b0);
      step("oh_10", 16'h0400, 4'd10, 1'b1, 1'b0);

      for (int k = 0; k < 16; k++) begin
         step($sformatf("walk_%0d", k), 16'(32'd1 << k), pe_idx_t'(k), 1'b1, 1'b0);
      end

      step("multi_0F00", 16'h0F00, 4'd11, 1'b1, 1'b1);
      step("multi_0101", 16'h0101, 4'd8,  1'b1, 1'b1);
      step("multi_8001", 16'h8001, 4'd15, 1'b1, 1'b1);
      step("multi_0006", 16'h0006, 4'd3,  1'b1, 1'b1);
      step("multi_FFFF", 16'hFFFF, 4'd15, 1'b1, 1'b1);
      step("zero",       16'h0000, 4'd0,  1'b0, 1'b0);

      // Mid-cycle changes reach enc_comb at once while enc holds its captured value.
      step("comb_pre", 16'h0080, 4'd7, 1'b1, 1'b0);
      bus.gnt = 16'h0008;
      #1;
      chk("comb_a.enc_comb", 32'(bus.enc_comb), 32'd3);
      chk("comb_a.enc",      32'(bus.enc),      32'd7);
      #1;
      bus.gnt = 16'h0400;
      #1;
      chk("comb_b.enc_comb", 32'(bus.enc_comb), 32'd10);
      chk("comb_b.enc",      32'(bus.enc),      32'd7);
      @(posedge clock);
      #1;
      chk_regs("comb_cap", 4'd10, 1'b1, 1'b0);

      // Short reset pulse between edges during back-to-back traffic.
      step("stream_a", 16'h0F00, 4'd11, 1'b1, 1'b1);
      #1;
      reset_n = 1'b0;
      bus.gnt = 16'h0101;
      #1;
      chk_regs("pulse_low", 4'd0, 1'b0, 1'b0);
      chk("pulse_low.enc_comb", 32'(bus.enc_comb), 32'd8);
      #2;
      reset_n = 1'b1;
      #1;
      chk_regs("pulse_released", 4'd0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      chk_regs("pulse_resume", 4'd8, 1'b1, 1'b1);
      step("stream_b", 16'h2000, 4'd13, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
